// File: rtl/paralelo_serie_param.sv
// paralelo_serie_param: parallel-to-serial transmitter for the phy_tx path.
// WIDTH-bit words enter a DEPTH-entry FIFO through valid/ready and leave one bit
// per clk_8f cycle. IDLE_WORD (comma) frames fill the line when nothing is queued,
// and MIN_IDLE comma frames are always sent after reset so the receiver can lock.
//
// Optional build macro PS_PARITY_EN: appends one even-parity bit (^word) after the
// WIDTH data bits of every frame, data or idle (frame length WIDTH+1).
//
// Ports
//   clk_8f        in   serial bit clock, all logic on its rising edge
//   reset         in   asynchronous active-low reset
//   data_inP      in   parallel word
//   valid_in      in   data_inP valid
//   ready_out     out  FIFO can accept (combinational from registered level)
//   data_outS     out  serial line, registered
//   word_start    out  registered, high with the first bit of every frame
//   sending_data  out  registered, high for the whole frame when it carries data
//   fifo_level    out  queued words, 0..DEPTH, registered
module paralelo_serie_param #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
   parameter int unsigned      MIN_IDLE  = 2,
   parameter bit               MSB_FIRST = 1'b1
) (
   input  logic                    clk_8f,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        data_inP,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic                    data_outS,
   output logic                    word_start,
   output logic                    sending_data,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
`ifdef PS_PARITY_EN
   localparam int unsigned FL     = WIDTH + 1;
`else
   localparam int unsigned FL     = WIDTH;
`endif
   localparam int unsigned CNT_W  = $clog2(FL);
   localparam int unsigned IDLE_W = $clog2(MIN_IDLE + 1);

   typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q,      state_d;
   logic [IDLE_W-1:0]  idle_cnt_q,   idle_cnt_d;
   logic               start_q,      start_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [FL-1:0]      shift_q,      shift_d;
   logic               dout_q,       dout_d;
   logic               ws_q,         ws_d;
   logic               sending_q,    sending_d;
   logic [LVL_W-1:0]   level_q,      level_d;
   logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               push_c;
   logic               pop_c;
   logic               boundary_c;
   logic [WIDTH-1:0]   word_c;
   logic [FL-1:0]      frame_c;

   // Put the word into transmit order: result bit WIDTH-1 goes on the line first.
   function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      if (MSB_FIRST) r = w;
      else           r = {<<{w}};
      return r;
   endfunction

   assign ready_out  = reset & (level_q < LVL_W'(DEPTH));
   assign push_c     = valid_in & ready_out;
   // start_q marks the first edge after reset release, which always opens a frame.
   assign boundary_c = start_q | (cnt_q == CNT_W'(FL - 1));
   // Pop uses the registered level, so a word pushed on this edge is not visible yet.
   assign pop_c      = boundary_c & (state_q == RUN) & (level_q != '0);
   assign word_c     = pop_c ? mem_q[rd_ptr_q] : IDLE_WORD;

   // Frame image, first transmitted bit in the MSB position.
   always_comb begin
      frame_c = '0;
`ifdef PS_PARITY_EN
      frame_c = {order_bits(word_c), ^word_c};
`else
      frame_c = order_bits(word_c);
`endif
   end

   // Next-state logic: framing, sync sequencing and FIFO bookkeeping.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      start_d    = 1'b0;
      cnt_d      = cnt_q + CNT_W'(1);
      shift_d    = shift_q << 1;
      dout_d     = shift_q[FL-1];
      ws_d       = 1'b0;
      sending_d  = sending_q;
      level_d    = level_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (boundary_c) begin
         cnt_d     = '0;
         ws_d      = 1'b1;
         dout_d    = frame_c[FL-1];
         shift_d   = frame_c << 1;
         sending_d = pop_c;
         // Idle frames are counted as they are loaded; the last one is still sent in
         // SYNC, so data can follow it immediately at the next boundary.
         if (state_q == SYNC) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            if (idle_cnt_q == IDLE_W'(MIN_IDLE - 1)) state_d = RUN;
         end
      end

      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push_c, pop_c})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state_q    <= SYNC;
         idle_cnt_q <= '0;
         start_q    <= 1'b1;
         cnt_q      <= '0;
         shift_q    <= '0;
         dout_q     <= 1'b0;
         ws_q       <= 1'b0;
         sending_q  <= 1'b0;
         level_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         start_q    <= start_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         dout_q     <= dout_d;
         ws_q       <= ws_d;
         sending_q  <= sending_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are meaningless while the level says empty, so no reset.
   always_ff @(posedge clk_8f) begin
      if (push_c) mem_q[wr_ptr_q] <= data_inP;
   end

   assign data_outS    = dout_q;
   assign word_start   = ws_q;
   assign sending_data = sending_q;
   assign fifo_level   = level_q;

endmodule
